// File: rtl/ws2812_string_driver_if.sv
// ws2812_string_driver_if: valid/ready pixel stream into the WS2812 string driver.
//   in_valid  master->slave  pixel word valid
//   in_ready  slave->master  FIFO can accept a word this cycle
//   in_data   master->slave  24-bit {G,R,B} pixel, bit 23 sent first
//   in_last   master->slave  final pixel of a frame
interface ws2812_string_driver_if;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        in_last;

    modport master (output in_valid, in_data, in_last, input in_ready);
    modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/ws2812_string_driver.sv
// ws2812_string_driver: serializes queued 24-bit GRB pixels onto a single-wire WS2812 string.
//   wb_clk_i      clock
//   wb_rst_i      synchronous active-high reset
//   px            pixel stream (slave side of ws2812_string_driver_if)
//   underrun_clr  clears the sticky underrun flag
//   led_o         registered serial line to the LED string
//   busy_o        high while a frame is in progress or words are queued
//   frame_done_o  one-cycle pulse at the end of the latch period
//   underrun_o    sticky: the FIFO ran dry in the middle of a frame
//   fifo_level    current FIFO occupancy
module ws2812_string_driver #(
    parameter int T0H_CYC    = 16,
    parameter int T1H_CYC    = 32,
    parameter int TBIT_CYC   = 50,
    parameter int LATCH_CYC  = 2400,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    ws2812_string_driver_if.slave       px,
    input  logic                        underrun_clr,
    output logic                        led_o,
    output logic                        busy_o,
    output logic                        frame_done_o,
    output logic                        underrun_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    // One counter serves both the bit period and the latch period.
    localparam int CW = $clog2((TBIT_CYC > LATCH_CYC) ? TBIT_CYC : LATCH_CYC);

    typedef enum logic [1:0] {IDLE, BIT, LATCH} state_t;

    logic [24:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [24:0]   head;
    logic          push, pop, empty;

    state_t        state, state_n;
    logic [23:0]   shifter, shifter_n;
    logic          last_w, last_n;
    logic [4:0]    bitcnt, bitcnt_n;
    logic [CW-1:0] cyc, cyc_n;
    logic          set_ur, done, led_n;

    // in_ready ignores a same-cycle pop, so a full FIFO never accepts a word.
    assign px.in_ready = count != LW'(FIFO_DEPTH);
    assign push        = px.in_valid & px.in_ready;
    assign empty       = count == '0;
    assign head        = mem[rd_ptr];
    assign fifo_level  = count;
    assign busy_o      = (state != IDLE) || !empty;

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= {px.in_last, px.in_data};
    end

    always_comb begin
        state_n   = state;
        shifter_n = shifter;
        last_n    = last_w;
        bitcnt_n  = bitcnt;
        cyc_n     = cyc;
        pop       = 1'b0;
        set_ur    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop                 = 1'b1;
                    state_n             = BIT;
                    {last_n, shifter_n} = head;
                    bitcnt_n            = 5'd23;
                    cyc_n               = '0;
                end
            end
            BIT: begin
                if (cyc == CW'(TBIT_CYC - 1)) begin
                    cyc_n = '0;
                    if (bitcnt != 5'd0) begin
                        shifter_n = {shifter[22:0], 1'b0};
                        bitcnt_n  = bitcnt - 5'd1;
                    end else if (last_w) begin
                        state_n = LATCH;
                    end else if (!empty) begin
                        // Next pixel follows with no gap on the line.
                        pop                 = 1'b1;
                        {last_n, shifter_n} = head;
                        bitcnt_n            = 5'd23;
                    end else begin
                        // Truncate the frame: latch what was sent and flag it.
                        set_ur  = 1'b1;
                        state_n = LATCH;
                    end
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            LATCH: begin
                if (cyc == CW'(LATCH_CYC - 1)) begin
                    done    = 1'b1;
                    state_n = IDLE;
                    cyc_n   = '0;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // led_o is registered from the next state so the line is aligned with the bit counter.
        led_n = (state_n == BIT) &&
                (cyc_n < (shifter_n[23] ? CW'(T1H_CYC) : CW'(T0H_CYC)));
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            shifter      <= '0;
            last_w       <= 1'b0;
            bitcnt       <= '0;
            cyc          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            led_o        <= 1'b0;
            frame_done_o <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            state        <= state_n;
            shifter      <= shifter_n;
            last_w       <= last_n;
            bitcnt       <= bitcnt_n;
            cyc          <= cyc_n;
            wr_ptr       <= wr_ptr + AW'(push);
            rd_ptr       <= rd_ptr + AW'(pop);
            count        <= count + LW'(push) - LW'(pop);
            led_o        <= led_n;
            frame_done_o <= done;
            // A new underrun wins over a clear in the same cycle.
            underrun_o   <= set_ur | (underrun_o & ~underrun_clr);
        end
    end
endmodule

// File: tb/tb_ws2812_string_driver.sv
// tb_ws2812_string_driver: scoreboard bench decoding led_o back into pixel words.
module tb_ws2812_string_driver;
    localparam int T0H = 16, T1H = 32, TBIT = 50, LATCH = 2400, DEPTH = 8;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       underrun_clr = 1'b0;
    logic       led_o, busy_o, frame_done_o, underrun_o;
    logic [3:0] fifo_level;

    ws2812_string_driver_if px();

    ws2812_string_driver #(
        .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .LATCH_CYC(LATCH), .FIFO_DEPTH(DEPTH)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .px(px),
        .underrun_clr(underrun_clr),
        .led_o(led_o),
        .busy_o(busy_o),
        .frame_done_o(frame_done_o),
        .underrun_o(underrun_o),
        .fifo_level(fifo_level)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int          checks = 0, failures = 0, frames = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Monitor: measures high widths and rise-to-rise periods, rebuilds pixels, pops the scoreboard.
    int          hi_len, nbits, since_rise;
    logic [23:0] word;
    logic        prev_led, prev_done, in_frame;

    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            hi_len = 0; nbits = 0; since_rise = 0;
            prev_led = 0; prev_done = 0; in_frame = 0;
        end else begin
            since_rise++;
            if (led_o && !prev_led) begin
                if (in_frame) check("bit_period", since_rise, TBIT);
                since_rise = 0;
                in_frame = 1;
            end
            if (led_o) begin
                hi_len++;
            end else if (prev_led) begin
                checks++;
                if (hi_len != T0H && hi_len != T1H) begin
                    failures++;
                    $display("FAIL high_width got=%0d exp=%0d_or_%0d", hi_len, T0H, T1H);
                end
                word = {word[22:0], hi_len == T1H};
                nbits++;
                hi_len = 0;
                if (nbits == 24) begin
                    nbits = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL pixel_unexpected got=%06h exp=none", word);
                    end else begin
                        check("pixel", word, exp_q.pop_front());
                    end
                end
            end
            if (frame_done_o) begin
                if (prev_done) begin
                    checks++;
                    failures++;
                    $display("FAIL done_width got=2+ exp=1");
                end else begin
                    frames++;
                    check("latch_gap", since_rise, TBIT + LATCH);
                    check("frame_bits", nbits, 0);
                    in_frame = 0;
                end
            end
            prev_led = led_o;
            prev_done = frame_done_o;
        end
    end

    task automatic push(input logic [23:0] d, input logic l, output int waited, output int lvl);
        @(negedge wb_clk_i);
        px.in_valid = 1'b1;
        px.in_data = d;
        px.in_last = l;
        waited = 0;
        while (!px.in_ready && waited < 5000) begin
            @(negedge wb_clk_i);
            waited++;
        end
        lvl = int'(fifo_level);
        if (!px.in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout got=in_ready_0 exp=in_ready_1");
        end else begin
            @(posedge wb_clk_i);
            exp_q.push_back(d);
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!frame_done_o && n < limit) begin
            @(negedge wb_clk_i);
            n++;
        end
        check("done_seen", frame_done_o, 1);
    endtask

    task automatic wait_underrun(input int limit, output int n);
        n = 0;
        while (!underrun_o && n < limit) begin
            @(negedge wb_clk_i);
            n++;
        end
    endtask

    logic [23:0] tbl [10] = '{24'h123456, 24'hABCDEF, 24'h000001, 24'h800000, 24'hFFFFFF,
                              24'h5A5A5A, 24'hA5A5A5, 24'h0F0F0F, 24'hF0F0F0, 24'h00FF00};

    initial begin
        int w, l, n, seen;
        px.in_valid = 1'b0;
        px.in_data = '0;
        px.in_last = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        check("rst_led", led_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", frame_done_o, 0);
        check("rst_underrun", underrun_o, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", px.in_ready, 1);
        wb_rst_i = 1'b0;

        // Single pixel frame: latency and frame timing.
        push(24'h00FF00, 1'b1, w, l);
        @(negedge wb_clk_i);
        px.in_valid = 1'b0;
        check("led_before_pop", led_o, 0);
        check("level_after_push", fifo_level, 1);
        @(negedge wb_clk_i);
        check("first_rise", led_o, 1);
        check("level_after_pop", fifo_level, 0);
        check("busy_frame", busy_o, 1);
        wait_done(5000, n);
        check("done_latency", n, 24 * TBIT + LATCH);
        @(negedge wb_clk_i);
        check("idle_busy", busy_o, 0);

        // Ten pixels back to back with in_valid held: fill, stall, refill.
        for (int i = 0; i < 9; i++) push(tbl[i], 1'b0, w, l);
        @(negedge wb_clk_i);
        check("full_level", fifo_level, 8);
        check("full_ready", px.in_ready, 0);
        push(tbl[9], 1'b1, w, l);
        check("full_stalled", w > 0, 1);
        check("full_pop_level", l, 7);
        @(negedge wb_clk_i);
        px.in_valid = 1'b0;
        check("refill_level", fifo_level, 8);
        wait_done(20000, n);

        // Underrun after two pixels without last.
        push(24'hC0FFEE, 1'b0, w, l);
        push(24'h000000, 1'b0, w, l);
        @(negedge wb_clk_i);
        px.in_valid = 1'b0;
        check("u_rise", led_o, 1);
        wait_underrun(5000, n);
        check("underrun_time", n, 2 * 24 * TBIT);
        check("latch_low", led_o, 0);
        wait_done(5000, n);
        check("u_latch", n, LATCH);
        check("u_sticky", underrun_o, 1);
        @(negedge wb_clk_i);
        underrun_clr = 1'b1;
        @(negedge wb_clk_i);
        underrun_clr = 1'b0;
        check("u_clr", underrun_o, 0);

        // Underrun set while clear is held: set wins.
        @(negedge wb_clk_i);
        underrun_clr = 1'b1;
        push(24'h7E0081, 1'b0, w, l);
        @(negedge wb_clk_i);
        px.in_valid = 1'b0;
        wait_underrun(5000, n);
        check("ur_prio", underrun_o, 1);
        underrun_clr = 1'b0;
        @(negedge wb_clk_i);
        check("ur_hold", underrun_o, 1);
        wait_done(5000, n);
        @(negedge wb_clk_i);
        underrun_clr = 1'b1;
        @(negedge wb_clk_i);
        underrun_clr = 1'b0;

        // Reset in the middle of bit 5 with three words queued.
        push(24'h111111, 1'b0, w, l);
        push(24'h222222, 1'b0, w, l);
        push(24'h333333, 1'b0, w, l);
        push(24'h444444, 1'b0, w, l);
        @(negedge wb_clk_i);
        px.in_valid = 1'b0;
        repeat (260) @(negedge wb_clk_i);
        check("mid_level", fifo_level, 3);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        check("mr_led", led_o, 0);
        check("mr_level", fifo_level, 0);
        check("mr_busy", busy_o, 0);
        check("mr_ready", px.in_ready, 1);
        check("mr_underrun", underrun_o, 0);
        wb_rst_i = 1'b0;
        exp_q.delete();
        seen = 0;
        repeat (3000) begin
            @(negedge wb_clk_i);
            if (led_o || frame_done_o) seen = 1;
        end
        check("post_reset_quiet", seen, 0);

        check("frames", frames, 4);
        check("leftover", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
